// File: rtl/multiplicador_pkg.sv
// rtl/multiplicador_pkg.sv - shared state encoding and default width for the sequential multiplier
package multiplicador_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multiplicador_seq_ctrl.sv
// rtl/multiplicador_seq_ctrl.sv - sequencing FSM and bit counter for the shift-add multiplier
module multiplicador_seq_ctrl
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_st,
  output logic o_load,
  output logic o_step,
  output logic o_fix,
  output logic o_idle,
  output logic o_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter is parked at zero outside BUSY so the next capture always starts clean.
  always_ff @(posedge i_clk) begin
    if (i_rst || o_load || (o_step && w_last)) begin
      r_cnt <= '0;
    end else if (o_step) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    o_load = 1'b0;
    o_step = 1'b0;
    o_fix  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_st) begin
          o_load = 1'b1;
          w_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        o_step = 1'b1;
        if (w_last) begin
          w_next = ST_FIX;
        end
      end
      ST_FIX: begin
        o_fix  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign o_idle = (r_state == ST_IDLE);
  assign o_done = (r_state == ST_DONE);

endmodule

// File: rtl/multiplicador_seq.sv
// rtl/multiplicador_seq.sv - sequential shift-add multiplier, unsigned or two's-complement signed
module multiplicador_seq
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               St,
  input  logic               Sgn,
  input  logic [WIDTH-1:0]   Multiplicador,
  input  logic [WIDTH-1:0]   Multiplicando,
  output logic [2*WIDTH-1:0] Produto,
  output logic               Idle,
  output logic               Done
);

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic [WIDTH-1:0]   w_mag_mr;
  logic [WIDTH-1:0]   w_mag_md;
  logic               w_neg;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_acc_next;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_produto;

  multiplicador_seq_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_st   (St),
    .o_load (w_load),
    .o_step (w_step),
    .o_fix  (w_fix),
    .o_idle (Idle),
    .o_done (Done)
  );

  // Negating the most negative value wraps back to itself, which read as unsigned is 2^(WIDTH-1).
  assign w_mag_mr = (Sgn && Multiplicador[WIDTH-1]) ? -Multiplicador : Multiplicador;
  assign w_mag_md = (Sgn && Multiplicando[WIDTH-1]) ? -Multiplicando : Multiplicando;
  assign w_neg    = Sgn & (Multiplicador[WIDTH-1] ^ Multiplicando[WIDTH-1]);

  // Carry bit is always zero here (the previous shift cleared it), so the add cannot overflow.
  assign w_addend   = r_acc[0] ? r_mcand : '0;
  assign w_sum      = r_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};
  assign w_acc_next = {1'b0, w_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_produto <= '0;
    end else begin
      if (w_load) begin
        r_acc   <= {1'b0, {WIDTH{1'b0}}, w_mag_mr};
        r_mcand <= w_mag_md;
        r_neg   <= w_neg;
      end else if (w_step) begin
        r_acc <= w_acc_next;
      end
      if (w_fix) begin
        r_produto <= r_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
      end
    end
  end

  assign Produto = r_produto;

endmodule

// File: tb/tb_multiplicador_seq.sv
// tb/tb_multiplicador_seq.sv - scoreboard bench for multiplicador_seq at WIDTH 16, 8 and 3
module tb_multiplicador_seq;

  localparam int N_RAND  = 700;
  localparam int MAX_CYC = 90000;

  logic clk   = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int W = (g == 0) ? 16 : ((g == 1) ? 8 : 3);

    logic             rst   = 1'b1;
    logic             st    = 1'b0;
    logic             sgn   = 1'b0;
    logic [W-1:0]     mr    = '0;
    logic [W-1:0]     md    = '0;
    logic [2*W-1:0]   prod;
    logic             idle;
    logic             done;
    logic             rst_q = 1'b0;
    bit               fin   = 1'b0;
    logic [2*W-1:0]   exp_q[$];
    int               cyc_q[$];

    multiplicador_seq #(
      .WIDTH (W)
    ) u_dut (
      .Clk           (clk),
      .Rst           (rst),
      .St            (st),
      .Sgn           (sgn),
      .Multiplicador (mr),
      .Multiplicando (md),
      .Produto       (prod),
      .Idle          (idle),
      .Done          (done)
    );

    always @(posedge clk) rst_q <= rst;

    // Reference: plain integer product of the operands as interpreted by the mode.
    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      longint pa, pb, p;
      if (s) begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
      end else begin
        pa = longint'({1'b0, a});
        pb = longint'({1'b0, b});
      end
      p = pa * pb;
      return p[2*W-1:0];
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL W=%0d %s: got %h required %h", W, name, act, exp);
      end
    endtask

    task automatic scramble();
      sgn = 1'($urandom);
      mr  = W'($urandom);
      md  = W'($urandom);
    endtask

    task automatic wait_idle(input bit scr);
      int guard = 0;
      while (idle !== 1'b1 && guard < 4 * W + 20) begin
        if (scr) scramble();
        step();
        guard++;
      end
      check("idle_wait", 64'(idle), 64'd1);
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      sgn = s;
      mr  = a;
      md  = b;
      st  = 1'b1;
      exp_q.push_back(ref_mul(s, a, b));
      cyc_q.push_back(cyc + 1);
      step();
    endtask

    task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      wait_idle(1'b0);
      issue(s, a, b);
      st = 1'b0;
      scramble();
    endtask

    initial begin : drv
      logic [W-1:0] mn;
      logic [W-1:0] a, b;
      mn = '0;
      mn[W-1] = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      start(1'b0, '1, '1);
      start(1'b1, W'(-3), W'(5));
      start(1'b1, mn, mn);
      start(1'b1, mn, W'(1));
      start(1'b0, '0, '1);
      start(1'b1, '1, '0);
      start(1'b1, '0, mn);
      // St held high through BUSY/FIX/DONE with operands churning.
      wait_idle(1'b0);
      issue(1'b0, '1, W'(3));
      wait_idle(1'b1);
      issue(1'b1, mn, '1);
      st = 1'b0;
      // Reset mid-BUSY together with St: no Done for the aborted op.
      start(1'b0, '1, '1);
      wait_idle(1'b0);
      issue(1'b0, W'(5), W'(7));
      st = 1'b0;
      repeat (W / 2) step();
      rst = 1'b1;
      st  = 1'b1;
      step();
      rst = 1'b0;
      st  = 1'b0;
      void'(exp_q.pop_back());
      void'(cyc_q.pop_back());
      start(1'b1, W'(-3), W'(-3));
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N_RAND; i++) begin
          a = W'($urandom);
          b = W'($urandom);
          if ($urandom_range(7) == 0) a = '0;
          if ($urandom_range(7) == 0) b = '0;
          start(m == 1, a, b);
        end
      end
      for (int i = 0; i < 4 * W + 20 && exp_q.size() != 0; i++) step();
      check("drain", 64'(exp_q.size()), 64'd0);
      fin = 1'b1;
    end

    initial begin : mon
      logic [2*W-1:0] last;
      logic [2*W-1:0] ee;
      logic           prev_done;
      int             kk;
      last      = '0;
      prev_done = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_q) begin
          check("rst_idle", 64'(idle), 64'd1);
          check("rst_prod", 64'(prod), 64'd0);
          check("rst_done", 64'(done), 64'd0);
          last = '0;
        end else if (done === 1'b1) begin
          check("done_width", 64'(prev_done), 64'd0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL W=%0d unexpected_done: got Done=1 required no pending op", W);
          end else begin
            ee = exp_q.pop_front();
            kk = cyc_q.pop_front();
            check("produto", 64'(prod), 64'(ee));
            check("latency", 64'(cyc + 1 - kk), 64'(W + 2));
          end
          last = prod;
        end else begin
          check("hold", 64'(prod), 64'(last));
        end
        prev_done = (done === 1'b1);
      end
    end
  end

  initial begin : top_ctl
    int guard = 0;
    while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && guard < MAX_CYC) begin
      @(posedge clk);
      guard++;
    end
    tests++;
    if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
      fails++;
      $display("FAIL timeout: got %0d cycles without completion required under %0d", guard, MAX_CYC);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
